// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//   Shared types and constants for the instruction-memory loader.
//   - loader_state_t : loader FSM states
//   - HOLD_CYCLES    : cycles the CPU stays held after the last write retires
//   - IMEM_WORD_W    : instruction word width
package imem_loader_pkg;

   localparam int IMEM_WORD_W = 32;
   localparam int HOLD_CYCLES = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CHECK,
      ST_HOLD,
      ST_RUN
   } loader_state_t;

endpackage

// File: rtl/imem_word_counter.sv
// imem_word_counter
//   Word address counter for the image loader. One bit wider than the
//   address so the terminal count can never alias a live address.
//   Ports:
//     clk     - clock
//     rst     - asynchronous active-low reset
//     clr_i   - synchronous clear (wins over en_i)
//     en_i    - increment by one
//     addr_o  - current word address (low AW bits of the count)
//     tc_o    - count is at N-1 (final image word)
module imem_word_counter
   import imem_loader_pkg::*;
#(
   parameter int CNT_W = 11,
   parameter int AW    = 10,
   parameter int N     = 14
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_i,
   input  logic          en_i,
   output logic [AW-1:0] addr_o,
   output logic          tc_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)     cnt_d = '0;
      else if (en_i) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign addr_o = cnt_q[AW-1:0];
   assign tc_o   = (cnt_q == CNT_W'(N - 1));

endmodule

// File: rtl/imem_loader.sv
// imem_loader
//   Streams a program image into instruction memory and holds the CPU core
//   in reset until the image is complete.
//   Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing
//   modulo-2^32 sum word after the image; a mismatch sets err and leaves
//   the CPU held in IDLE. Without it, err is tied to 0.
//   Ports:
//     clk, rst          - clock, asynchronous active-low reset
//     start             - one-cycle pulse, begins a (re)load from IDLE/RUN
//     s_valid/s_data    - source word stream, s_ready - word accepted
//     imem_we/addr/wdata- registered instruction memory write port
//     cpu_rst_n         - active-low reset to the CPU core
//     busy/done/err     - status (LOAD/CHECK/HOLD, RUN, sticky error)
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int          IMEM_DEPTH    = 1024,
   parameter logic [31:0] MAX_INST_ADDR = 32'h34
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          s_valid,
   input  logic [IMEM_WORD_W-1:0]        s_data,
   output logic                          s_ready,
   output logic                          imem_we,
   output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
   output logic [IMEM_WORD_W-1:0]        imem_wdata,
   output logic                          cpu_rst_n,
   output logic                          busy,
   output logic                          done,
   output logic                          err
);

   localparam int AW    = $clog2(IMEM_DEPTH);
   localparam int CNT_W = AW + 1;
   localparam int N     = int'(MAX_INST_ADDR >> 2) + 1;
   localparam int HW    = $clog2(HOLD_CYCLES + 1);

   loader_state_t        state_q, state_d;
   logic [HW-1:0]        hold_q, hold_d;
   logic                 s_ready_q, imem_we_q, cpu_rst_n_q, busy_q, done_q;
   logic [AW-1:0]        imem_addr_q;
   logic [IMEM_WORD_W-1:0] imem_wdata_q;

   logic          fire, load_fire, start_ok, tc;
   logic [AW-1:0] cnt_addr;

   // s_ready_q mirrors the state, so a transfer is simply valid while ready
   assign fire      = s_valid && s_ready_q;
   assign load_fire = fire && (state_q == ST_LOAD);
   // start only acts outside an image in progress
   assign start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_RUN));

   imem_word_counter #(
      .CNT_W (CNT_W),
      .AW    (AW),
      .N     (N)
   ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (start_ok),
      .en_i   (load_fire),
      .addr_o (cnt_addr),
      .tc_o   (tc)
   );

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [IMEM_WORD_W-1:0] sum_q;
   logic                   err_q, err_d;
`endif

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      err_d   = err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_LOAD;
`ifdef IMEM_LOADER_CHECKSUM_EN
               err_d   = 1'b0;
`endif
            end
         end
         ST_LOAD: begin
            if (load_fire && tc) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_d = ST_CHECK;
`else
               state_d = ST_HOLD;
`endif
               hold_d  = '0;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         ST_CHECK: begin
            if (fire) begin
               if (s_data == sum_q) begin
                  state_d = ST_HOLD;
                  hold_d  = '0;
               end else begin
                  state_d = ST_IDLE;
                  err_d   = 1'b1;
               end
            end
         end
`endif
         ST_HOLD: begin
            // The first HOLD cycle carries the final write; the CPU is then
            // kept in reset for HOLD_CYCLES more cycles after it retires.
            if (hold_q == HW'(HOLD_CYCLES)) state_d = ST_RUN;
            else                            hold_d  = hold_q + 1'b1;
         end
         ST_RUN: begin
            if (start) state_d = ST_LOAD;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // All outputs are registered from the next state, so cpu_rst_n drops on
   // the same edge that accepts a restart from RUN.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         hold_q       <= '0;
         s_ready_q    <= 1'b0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         cpu_rst_n_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         s_ready_q   <= (state_d == ST_LOAD) || (state_d == ST_CHECK);
         cpu_rst_n_q <= (state_d == ST_RUN);
         busy_q      <= (state_d == ST_LOAD) || (state_d == ST_CHECK) ||
                        (state_d == ST_HOLD);
         done_q      <= (state_d == ST_RUN);
         imem_we_q   <= load_fire;
         if (load_fire) begin
            imem_addr_q  <= cnt_addr;
            imem_wdata_q <= s_data;
         end
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sum_q <= '0;
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
         if (start_ok)       sum_q <= '0;
         else if (load_fire) sum_q <= sum_q + s_data;
      end
   end
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign s_ready    = s_ready_q;
   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign cpu_rst_n  = cpu_rst_n_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Randomized self-checking bench for imem_loader. The reference is the
//   transaction view: every accepted word becomes one write at the next
//   contiguous address one cycle later, the CPU is released three cycles
//   after the last write pulse, and the written memory equals the image.
module tb_imem_loader;

   localparam int DEPTH = 1024;
   localparam int N     = 14;
   localparam int AW    = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          s_valid;
   logic [31:0]   s_data;
   logic          s_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          cpu_rst_n;
   logic          busy;
   logic          done;
   logic          err;

   imem_loader #(
      .IMEM_DEPTH    (DEPTH),
      .MAX_INST_ADDR (32'h34)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .s_valid    (s_valid),
      .s_data     (s_data),
      .s_ready    (s_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_rst_n  (cpu_rst_n),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // memory as seen by the write port
   logic [31:0] mem_obs [DEPTH];
   int          wr_cnt = 0;
   always @(posedge clk) begin
      if (imem_we) begin
         mem_obs[imem_addr] <= imem_wdata;
         wr_cnt <= wr_cnt + 1;
      end
   end

   logic [31:0] image [N];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, 32'(s_ready), 32'd0);
      chk({tag, "_we"},    32'(imem_we), 32'd0);
      chk({tag, "_addr"},  32'(imem_addr), 32'd0);
      chk({tag, "_wdata"}, imem_wdata, 32'd0);
      chk({tag, "_rstn"},  32'(cpu_rst_n), 32'd0);
      chk({tag, "_busy"},  32'(busy), 32'd0);
      chk({tag, "_done"},  32'(done), 32'd0);
      chk({tag, "_err"},   32'(err), 32'd0);
   endtask

   // vmode: 0 = valid every cycle, 1 = toggle 1,0,1,0, 2 = random
   // start_at: word index at which a stray start is pulsed (-1 none)
   // rst_at:   word index at which reset is asserted mid-cycle (-1 none)
   // cks:      0 = no sum word, 1 = correct sum word, 2 = sum+1
   task automatic do_load(input string tag, input int vmode, input int start_at,
                          input int rst_at, input bit pattern, input int cks);
      int          k;
      int          total;
      int          wr_base;
      bit          acc, wr, poked;
      logic [31:0] sum;
      k = 0; sum = '0; poked = 0;
      total = N + ((cks != 0) ? 1 : 0);
      wr_base = wr_cnt;
      start = 1'b1; s_valid = 1'b0; s_data = $urandom();
      tick();
      start = 1'b0;
      chk({tag, "_st_rstn"},  32'(cpu_rst_n), 32'd0);
      chk({tag, "_st_ready"}, 32'(s_ready), 32'd1);
      chk({tag, "_st_busy"},  32'(busy), 32'd1);
      chk({tag, "_st_done"},  32'(done), 32'd0);
      chk({tag, "_st_err"},   32'(err), 32'd0);
      for (int c = 0; c < 2000 && k < total; c++) begin
         case (vmode)
            0:       s_valid = 1'b1;
            1:       s_valid = (c % 2 == 0);
            default: s_valid = ($urandom_range(99) < 60);
         endcase
         if (k < N) s_data = pattern ? (32'h13 + 32'(k)) : $urandom();
         else       s_data = sum + ((cks == 2) ? 32'd1 : 32'd0);
         start = 1'b0;
         if (!poked && k == start_at) begin
            start = 1'b1;
            poked = 1;
         end
         if (rst_at >= 0 && k == rst_at && s_valid) begin
            #2 rst = 1'b0;
            #1;
            chk_reset_vals({tag, "_midrst"});
            start = 1'b0; s_valid = 1'b0;
            tick(); tick();
            rst = 1'b1;
            tick();
            chk_reset_vals({tag, "_postrst"});
            return;
         end
         acc = s_valid;
         wr  = acc && (k < N);
         if (wr) begin
            image[k] = s_data;
            sum += s_data;
         end
         tick();
         if (wr) begin
            chk({tag, "_we"},    32'(imem_we), 32'd1);
            chk({tag, "_addr"},  32'(imem_addr), 32'(k));
            chk({tag, "_wdata"}, imem_wdata, image[k]);
         end else begin
            chk({tag, "_nowe"}, 32'(imem_we), 32'd0);
         end
         if (acc) k++;
         chk({tag, "_ready"}, 32'(s_ready), 32'(k < total));
      end
      start = 1'b0; s_valid = 1'b0;
      if (k < total) begin
         chk({tag, "_timeout_words"}, 32'(k), 32'(total));
         return;
      end
      if (cks == 2) begin
         chk({tag, "_bad_err"},  32'(err), 32'd1);
         chk({tag, "_bad_busy"}, 32'(busy), 32'd0);
         for (int i = 0; i < 4; i++) begin
            tick();
            chk({tag, "_bad_rstn"}, 32'(cpu_rst_n), 32'd0);
            chk({tag, "_bad_done"}, 32'(done), 32'd0);
         end
         chk({tag, "_bad_err_sticky"}, 32'(err), 32'd1);
         return;
      end
      // release lands exactly three cycles after the last write pulse
      // (or after the accepted sum word)
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk({tag, "_rel_rstn"}, 32'(cpu_rst_n), 32'(i == 3));
         chk({tag, "_rel_busy"}, 32'(busy), 32'(i != 3));
         chk({tag, "_rel_we"},   32'(imem_we), 32'd0);
      end
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_err"},  32'(err), 32'd0);
      chk({tag, "_nwr"},  32'(wr_cnt - wr_base), 32'(N));
      for (int i = 0; i < N; i++) chk({tag, "_mem"}, mem_obs[i], image[i]);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0;
      #1;
      chk_reset_vals("por");
      tick(); tick();
      rst = 1'b1;
      // idle: offered words are not consumed
      for (int i = 0; i < 3; i++) begin
         s_valid = 1'b1; s_data = $urandom();
         tick();
         chk("idle_we", 32'(imem_we), 32'd0);
         chk("idle_ready", 32'(s_ready), 32'd0);
         chk("idle_rstn", 32'(cpu_rst_n), 32'd0);
      end
      s_valid = 1'b0;

      do_load("seq", 0, -1, -1, 1'b1, 0);
      // restart from RUN with a toggling source
      chk("run_rstn_pre", 32'(cpu_rst_n), 32'd1);
      do_load("toggle", 1, -1, -1, 1'b0, 0);
      do_load("stray_start", 2, 5, -1, 1'b0, 0);
      do_load("rand", 2, -1, -1, 1'b0, 0);
      do_load("abort", 0, -1, 7, 1'b0, 0);
      do_load("after_rst", 0, -1, -1, 1'b0, 0);
      // RUN stays quiet with source traffic
      for (int i = 0; i < 3; i++) begin
         s_valid = 1'b1; s_data = $urandom();
         tick();
         chk("run_we", 32'(imem_we), 32'd0);
         chk("run_done", 32'(done), 32'd1);
      end
      s_valid = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      do_load("cks_good", 2, -1, -1, 1'b0, 1);
      do_load("cks_bad", 0, -1, -1, 1'b0, 2);
      do_load("cks_retry", 1, -1, -1, 1'b0, 1);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
